// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and constants for the instruction fetch queue
package ifq_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DROP = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - circular prefetch buffer holding {inst, pc4} entries
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail (ignored when full)
//   push_data    entry to enqueue
//   pop          drop the head entry (ignored when empty)
//   clear        discard every entry; wins over push and pop
//   head_data    entry at the head (meaningless when empty)
//   count        number of valid entries, 0..DEPTH
//   full, empty  occupancy flags
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch front end with prefetch queue and redirect handling
//
// Optional feature macro: IFQ_BYPASS_EN (response forwarded to the outputs when the queue is empty)
//
// Ports:
//   Clock, Resetn    clock, asynchronous active-low reset
//   stall            hold the presented instruction
//   pcsource         00 seq, 01 branch (bpc), 10 jump (jpc), 11 seq
//   bpc, jpc         redirect targets (low two bits ignored)
//   imem_req/addr    word read request to instruction memory
//   imem_gnt         request accepted this cycle
//   imem_rvalid/rdata read response
//   if_valid         if_inst/if_pc4 carry a real instruction
//   if_inst          instruction for IF/ID, NOP when not valid
//   if_pc4           address of if_inst + 4
//   PC               address of the presented instruction (fetch PC when empty)
module if_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc4,
  output logic [31:0] PC
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_nxt;
  logic         run_en;

  logic         redirect;
  logic [31:0]  target;
  logic         in_flight;
  logic [CW:0]  occupancy;
  logic         room;
  logic         grant;
  logic         resp_take;
  ifq_entry_t   resp_entry;
  logic         bypass_hit;

  logic         q_push;
  logic         q_pop;
  ifq_entry_t   q_head;
  logic [CW-1:0] q_count;
  logic         q_full;
  logic         q_empty;

  ifq_entry_t   out_entry;
  logic         out_valid;

  assign redirect = (pcsource == PCSRC_BR) || (pcsource == PCSRC_JMP);
  assign target   = word_align((pcsource == PCSRC_BR) ? bpc : jpc);

  // Requests only leave from IDLE, so in_flight is zero whenever a request
  // is considered; it is kept so the room test reads as queue + outstanding.
  assign in_flight = (state == ST_WAIT);
  assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, in_flight};
  assign room      = occupancy < (CW+1)'(DEPTH);

  // run_en keeps the request low for the first cycle out of reset.
  assign imem_req  = run_en && (state == ST_IDLE) && !redirect && room;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // A response is accepted in WAIT, or in IDLE when it arrives together
  // with its own grant (zero-latency memory). Stray data in IDLE and all
  // data in DROP or in a redirect cycle are discarded.
  assign resp_take = imem_rvalid && !redirect && ((state == ST_WAIT) || grant);

  // In WAIT fetch_pc already advanced past the outstanding word.
  assign resp_entry.inst = imem_rdata;
  assign resp_entry.pc4  = (state == ST_WAIT) ? fetch_pc : fetch_pc + 32'd4;

`ifdef IFQ_BYPASS_EN
  assign bypass_hit = q_empty && resp_take;
`else
  assign bypass_hit = 1'b0;
`endif

  assign q_pop  = !q_empty && !stall;
  assign q_push = resp_take && !q_full && !(bypass_hit && !stall);

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (Resetn),
    .push      (q_push),
    .push_data (resp_entry),
    .pop       (q_pop),
    .clear     (redirect),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      run_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      run_en   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      ST_IDLE: begin
        if (grant) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          if (!imem_rvalid) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid)   state_nxt = ST_IDLE;
        else if (redirect) state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (imem_rvalid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (redirect) fetch_pc_nxt = target;
  end

  always_comb begin
    out_entry = resp_entry;
    out_valid = 1'b0;
    if (!q_empty) begin
      out_entry = q_head;
      out_valid = 1'b1;
    end else if (bypass_hit) begin
      out_entry = resp_entry;
      out_valid = 1'b1;
    end
  end

  assign if_valid = out_valid;
  assign if_inst  = out_valid ? out_entry.inst : NOP_INST;
  assign if_pc4   = out_valid ? out_entry.pc4 : fetch_pc + 32'd4;
  assign PC       = out_valid ? out_entry.pc4 - 32'd4 : fetch_pc;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized scoreboard bench for if_fetch_queue
module tb_if_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFQ_BYPASS_EN
  localparam int EXP_LAT1 = 1;
`else
  localparam int EXP_LAT1 = 2;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic [31:0] PC;

  if_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .Clock       (clk),
    .Resetn      (rst_n),
    .stall       (stall),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc4      (if_pc4),
    .PC          (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_consumed = 0;
  int cyc = 0;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;

  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_pct = 100;

  bit          last_gnt;
  logic        snap_valid;
  logic        snap_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h8BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected program stream: sequential words from gen_pc onward.
  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{inst: mem_word(gen_pc), pc4: gen_pc + 32'd4});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  // One clock of stimulus plus the memory model; the expected stream is
  // updated after the monitor has sampled this cycle.
  task automatic step(input logic st, input logic [1:0] ps, input logic [31:0] b, input logic [31:0] j);
    int k;
    bit redir;
    @(negedge clk);
    cyc++;
    stall = st; pcsource = ps; bpc = b; jpc = j;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; last_gnt = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_busy    = 1'b0;
      end
    end
    #1;
    redir = (ps == 2'b01) || (ps == 2'b10);
    if (redir) check("req_low_on_redirect", {31'b0, imem_req}, 32'd0);
    if (imem_req && !mem_busy && !imem_rvalid && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt = 1'b1;
      last_gnt = 1'b1;
      check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
      k = $urandom_range(lat_max, lat_min);
      if (k == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(imem_addr);
      end else begin
        mem_busy = 1'b1;
        mem_cnt  = k;
        mem_addr = imem_addr;
      end
    end
    #1;
    snap_valid = if_valid;
    snap_req   = imem_req;
    #1;
    if (redir) begin
      exp_q.delete();
      gen_pc = ((ps == 2'b01) ? b : j) & 32'hFFFF_FFFC;
    end
    top_up();
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; pcsource = 2'b00;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    #2;
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_pc4", if_pc4, RESET_PC + 32'd4);
    check("rst_pc", PC, RESET_PC);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    gen_pc = RESET_PC;
    top_up();
    // A stray response from before reset lands two cycles after release.
    mem_busy = stray;
    mem_cnt  = 2;
  endtask

  // Monitor: compares every consumed instruction against the expected stream.
  bit          prev_hold = 0;
  logic [31:0] prev_inst;
  logic [31:0] prev_pc4;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check("stall_hold_valid", {31'b0, if_valid}, 32'd1);
        check("stall_hold_inst", if_inst, prev_inst);
        check("stall_hold_pc4", if_pc4, prev_pc4);
      end
      if (if_valid) check("pc_matches_pc4", PC, if_pc4 - 32'd4);
      else          check("nop_when_invalid", if_inst, 32'h0);
      if (if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("stream_inst", if_inst, e.inst);
          check("stream_pc4", if_pc4, e.pc4);
          n_consumed++;
        end
      end
      prev_hold = if_valid && stall && !((pcsource == 2'b01) || (pcsource == 2'b10));
      prev_inst = if_inst;
      prev_pc4  = if_pc4;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_g;
    int first_v;
    int cons0;
    bit got;
    logic [1:0] ps;
    rst_n = 1'b0; stall = 1'b0; pcsource = 2'b00; bpc = '0; jpc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    gen_pc = RESET_PC;

    // Fixed 1-cycle memory, no stall: sequential stream and first latency.
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    do_reset(0);
    first_g = -1; first_v = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 2'b00, $urandom, $urandom);
      if (last_gnt && first_g < 0) first_g = cyc;
      if (snap_valid && first_v < 0) first_v = cyc;
    end
    check("first_latency", first_v - first_g, EXP_LAT1);

    // Long stall: queue fills, request drops, outputs frozen.
    for (int i = 0; i < 12; i++) step(1'b1, 2'b00, $urandom, $urandom);
    check("stall_full_req", {31'b0, snap_req}, 32'd0);
    check("stall_full_valid", {31'b0, snap_valid}, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 2'b00, $urandom, $urandom);

    // Branch while a request is outstanding.
    lat_min = 3; lat_max = 3;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 2'b00, $urandom, $urandom);
      got = last_gnt;
    end
    check("br_grant_seen", {31'b0, got}, 32'd1);
    step(1'b0, 2'b01, 32'h41, $urandom);
    step(1'b0, 2'b00, $urandom, $urandom);
    check("br_flush_valid", {31'b0, snap_valid}, 32'd0);
    cons0 = n_consumed;
    for (int i = 0; i < 30; i++) step(1'b0, 2'b00, $urandom, $urandom);
    check("br_progress", {31'b0, (n_consumed > cons0)}, 32'd1);

    // Jump with stall and response in the same cycle.
    lat_min = 2; lat_max = 2;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step(1'b0, 2'b00, $urandom, $urandom);
      got = mem_busy && (mem_cnt == 1);
    end
    check("jmp_resp_due", {31'b0, got}, 32'd1);
    step(1'b1, 2'b10, $urandom, 32'h100);
    step(1'b0, 2'b00, $urandom, $urandom);
    check("jmp_flush_valid", {31'b0, snap_valid}, 32'd0);
    for (int i = 0; i < 30; i++) step(1'b0, 2'b00, $urandom, $urandom);

    // Reset during WAIT with a stray response after release.
    lat_min = 4; lat_max = 4;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 2'b00, $urandom, $urandom);
      got = last_gnt;
    end
    check("rst_grant_seen", {31'b0, got}, 32'd1);
    step(1'b0, 2'b00, $urandom, $urandom);
    do_reset(1);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 30; i++) step(1'b0, 2'b00, $urandom, $urandom);

    // Random latency, grant, stall and redirects.
    lat_min = 0; lat_max = 5; gnt_pct = 70;
    cons0 = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(99))
        0, 1, 2, 3, 4: ps = 2'b01;
        5, 6, 7:       ps = 2'b10;
        8, 9, 10:      ps = 2'b11;
        default:       ps = 2'b00;
      endcase
      step(($urandom_range(99) < 30), ps, $urandom & 32'h0000_0FFF, $urandom & 32'h0000_0FFF);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 2'b00, $urandom, $urandom);
    check("random_progress", {31'b0, ((n_consumed - cons0) > 100)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
